aes_ydata_pack: RTL and testbench

//   Byte-stream to block packer: accepts AES state bytes one per cycle over a

---
 rtl/aes_ydata_pack.sv | 59 +++++
 tb/tb_aes_ydata_pack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_ydata_pack.sv
// Byte-stream to block packer: collects 4*Nb AES state bytes, first byte in the MSB,
// and presents the assembled block behind a valid/ready output register.
module aes_ydata_pack #(
   parameter int Nb = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 in_byte,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [32*Nb-1:0]           data_out,
   output logic [$clog2(4*Nb)-1:0]    fill
);

   localparam int NBYTES = 4*Nb;
   localparam int W      = 32*Nb;
   localparam int FW     = $clog2(NBYTES);
   localparam logic [FW-1:0] LAST = FW'(NBYTES-1);

   logic [W-1:0] acc;
   logic         accept;
   logic         drain;
   logic         last;

   // Only the closing byte needs a free output register; earlier bytes go to acc.
   assign in_ready = !clear && (fill != LAST || !out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;
   assign last     = accept && (fill == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         fill      <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else begin
         if (clear) begin
            fill <= '0;
            acc  <= '0;
         end else if (last) begin
            data_out  <= {acc[W-1:8], in_byte};
            out_valid <= 1'b1;
            fill      <= '0;
            acc       <= '0;
         end else if (accept) begin
            for (int k = 0; k < NBYTES-1; k++) begin
               if (fill == FW'(k)) acc[W-1-8*k -: 8] <= in_byte;
            end
            fill <= fill + FW'(1);
         end
         if (drain && !last) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_ydata_pack.sv
// Bench for aes_ydata_pack: directed vectors with literal expectations plus a
// byte-list reference packer compared against the DUT on every cycle.
module tb_aes_ydata_pack;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clear = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_byte = 8'h00;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] data_out;
   logic [3:0]   fill;

   aes_ydata_pack #(.Nb(4)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_byte(in_byte), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .fill(fill)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int stalls = 0;
   bit rnd = 1'b0;
   bit sb_on = 1'b0;
   int n_drained = 0;
   logic [127:0] exp_q[$];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference packer: a list of collected bytes and a held output block.
   bit           m_on = 1'b0;
   int           m_cnt = 0;
   logic [7:0]   m_bytes[16];
   logic [127:0] m_out = '0;
   bit           m_valid = 1'b0;

   function automatic bit m_ready();
      return !clear && (m_cnt != 15 || !m_valid || out_ready);
   endfunction

   always @(posedge clk) begin
      bit drain, take, done;
      if (!rst) begin
         m_on = 1'b1; m_cnt = 0; m_out = '0; m_valid = 1'b0;
      end else if (m_on) begin
         drain = m_valid && out_ready;
         take  = in_valid && m_ready();
         done  = 1'b0;
         if (clear) m_cnt = 0;
         else if (take) begin
            m_bytes[m_cnt] = in_byte;
            m_cnt++;
            if (m_cnt == 16) begin
               for (int k = 0; k < 16; k++) m_out[127-8*k -: 8] = m_bytes[k];
               m_valid = 1'b1;
               m_cnt = 0;
               done = 1'b1;
            end
         end
         if (drain && !done) m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("mdl_out_valid", 128'(out_valid), 128'(m_valid));
         chk("mdl_fill", 128'(fill), 128'(m_cnt));
         chk("mdl_in_ready", 128'(in_ready), 128'(m_ready()));
         chk("mdl_data_out", data_out, m_out);
      end
      if (sb_on && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("sb_extra_block", data_out, 128'hx);
         else chk("sb_block", data_out, exp_q.pop_front());
         n_drained++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bit done = 1'b0;
      if (rnd) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; in_byte = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b1; in_byte = b;
      while (!done) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else begin
            stalls++;
            n++;
            if (n > 200) begin
               chk("send_timeout", 128'(n), 128'd0);
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] fips[16] = '{8'h32, 8'h43, 8'hf6, 8'ha8, 8'h88, 8'h5a, 8'h30, 8'h8d,
                               8'h31, 8'h31, 8'h98, 8'ha2, 8'he0, 8'h37, 8'h07, 8'h34};
      logic [127:0] blk;

      // 1: reset state
      do_reset();
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_data_out", data_out, 128'd0);
      chk("rst_fill", 128'(fill), 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd1);

      // 2: counting bytes back-to-back
      out_ready = 1'b1;
      stalls = 0;
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      chk("cnt_stalls", 128'(stalls), 128'd0);
      chk("cnt_out_valid", 128'(out_valid), 128'd1);
      chk("cnt_data", data_out, 128'h000102030405060708090a0b0c0d0e0f);
      @(posedge clk); #1;
      chk("cnt_drained", 128'(out_valid), 128'd0);

      // 3: FIPS-197 plaintext
      for (int i = 0; i < 16; i++) send_byte(fips[i]);
      chk("fips_data", data_out, 128'h3243f6a8885a308d313198a2e0370734);
      @(posedge clk); #1;

      // 4: output back-pressure, only the closing byte stalls
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
      stalls = 0;
      for (int i = 0; i < 15; i++) send_byte(8'h30 + 8'(i));
      chk("bp_early_stalls", 128'(stalls), 128'd0);
      in_valid = 1'b1; in_byte = 8'h3f;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_low", 128'(in_ready), 128'd0);
         chk("bp_hold_data", data_out, 128'h101112131415161718191a1b1c1d1e1f);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_high", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_valid_cont", 128'(out_valid), 128'd1);
      chk("bp_block2", data_out, 128'h303132333435363738393a3b3c3d3e3f);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_drained", 128'(out_valid), 128'd0);

      // 5: clear drops a partial block
      for (int i = 0; i < 5; i++) send_byte(8'hc0 + 8'(i));
      clear = 1'b1; in_valid = 1'b1; in_byte = 8'hff;
      @(negedge clk);
      chk("clr_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_fill", 128'(fill), 128'd0);
      for (int i = 0; i < 16; i++) send_byte(8'haa + 8'(i));
      chk("clr_data", data_out, 128'haaabacadaeafb0b1b2b3b4b5b6b7b8b9);
      @(posedge clk); #1;

      // 6: reset mid-block, then random traffic against the scoreboard
      for (int i = 0; i < 7; i++) send_byte(8'he0 + 8'(i));
      do_reset();
      chk("rst6_fill", 128'(fill), 128'd0);
      chk("rst6_out_valid", 128'(out_valid), 128'd0);
      sb_on = 1'b1;
      rnd = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = 8'($urandom);
         exp_q.push_back(blk);
         for (int k = 0; k < 16; k++) send_byte(blk[127-8*k -: 8]);
      end
      rnd = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("sb_pending", 128'(exp_q.size()), 128'd0);
      chk("sb_count", 128'(n_drained), 128'd100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
